decap_packet: RTL

Receive-side counterpart of the input-port packet encapsulator. Takes the stream of 64-bit Aurora words, each carrying a HEADER_WIDTH-bit header in the low bits and a PAYLOAD_WIDTH-bit payload slice above it. Reassembles NUMBER_PACKET consecutive payload slices into one DATA_DFX_WIDTH-bit DFX word (data plus address) and presents it with its header. Sits between the Aurora RX user interface and the output-port logic.

---
 rtl/decap_packet_if.sv | 24 ++
 rtl/decap_packet.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/decap_packet_if.sv
// Aurora RX beat stream in, reassembled DFX word out.
// The slave modport is the decapsulator's view of the link.
interface decap_packet_if #(
   parameter int AURORA_DATA_WIDTH = 64,
   parameter int DATA_DFX_WIDTH    = 1034,
   parameter int HEADER_WIDTH      = 9
);
   logic [AURORA_DATA_WIDTH-1:0] data_in;
   logic                         data_in_valid;
   logic [DATA_DFX_WIDTH-1:0]    data_dfx_recv;
   logic [HEADER_WIDTH-1:0]      header_pkt_recv;
   logic                         data_dfx_valid;
   logic                         pkt_error;

   modport master (
      output data_in, data_in_valid,
      input  data_dfx_recv, header_pkt_recv, data_dfx_valid, pkt_error
   );

   modport slave (
      input  data_in, data_in_valid,
      output data_dfx_recv, header_pkt_recv, data_dfx_valid, pkt_error
   );
endinterface

// File: rtl/decap_packet.sv
// Reassembles NUMBER_PACKET header-tagged Aurora beats into one DFX word.
// Aborts on a header change inside a packet or on a long idle gap.
//
//   state     | meaning
//   S_IDLE    | waiting for beat 0 of a packet
//   S_COLLECT | beats 1..NUMBER_PACKET-1 expected, idle-gap timer running
module decap_packet #(
   parameter int DATA_WIDTH             = 1024,
   parameter int ADDR_WIDTH             = 10,
   parameter int DATA_DFX_WIDTH         = DATA_WIDTH + ADDR_WIDTH,
   parameter int RECOGNIZE_ROUTER_WIDTH = 2,
   parameter int NUMBER_PACKET          = 19,
   parameter int TTL_WIDTH              = $clog2(3),
   parameter int HEADER_WIDTH           = RECOGNIZE_ROUTER_WIDTH + $clog2(NUMBER_PACKET) + TTL_WIDTH,
   parameter int AURORA_DATA_WIDTH      = 64,
   parameter int PAYLOAD_WIDTH          = AURORA_DATA_WIDTH - HEADER_WIDTH,
   parameter int TIMEOUT_CYCLES         = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   decap_packet_if.slave  bus
);

   localparam int CNT_W   = $clog2(NUMBER_PACKET);
   localparam int TMO_W   = $clog2(TIMEOUT_CYCLES);
   localparam int LAST_LO = (NUMBER_PACKET - 1) * PAYLOAD_WIDTH;
   localparam int LAST_W  = DATA_DFX_WIDTH - LAST_LO;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUMBER_PACKET - 1);
   localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic {S_IDLE, S_COLLECT} state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          beat_q, beat_d;
   logic [TMO_W-1:0]          tmo_q, tmo_d;
   logic [HEADER_WIDTH-1:0]   hdr_q, hdr_d;
   logic [DATA_DFX_WIDTH-1:0] asm_q, asm_d;
   logic [DATA_DFX_WIDTH-1:0] dfx_q;
   logic [HEADER_WIDTH-1:0]   hdr_out_q;
   logic                      valid_q, err_q;
   logic                      wr_en, done, abort;

   logic [HEADER_WIDTH-1:0]  hdr_in;
   logic [PAYLOAD_WIDTH-1:0] payload;

   assign hdr_in  = bus.data_in[HEADER_WIDTH-1:0];
   assign payload = bus.data_in[AURORA_DATA_WIDTH-1:HEADER_WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         tmo_q   <= '0;
         hdr_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         tmo_q   <= tmo_d;
         hdr_q   <= hdr_d;
      end
   end

   // Gap timer is a down-counter reloaded on every accepted beat; terminal
   // count on an idle cycle means TIMEOUT_CYCLES consecutive idles.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      tmo_d   = tmo_q;
      hdr_d   = hdr_q;
      wr_en   = 1'b0;
      done    = 1'b0;
      abort   = 1'b0;
      case (state_q)
         S_IDLE: begin
            beat_d = '0;
            if (bus.data_in_valid) begin
               hdr_d   = hdr_in;
               wr_en   = 1'b1;
               beat_d  = CNT_W'(1);
               tmo_d   = TMO_LOAD;
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (bus.data_in_valid) begin
               tmo_d = TMO_LOAD;
               if (hdr_in != hdr_q) begin
                  abort   = 1'b1;
                  beat_d  = '0;
                  state_d = S_IDLE;
               end else begin
                  wr_en = 1'b1;
                  if (beat_q == LAST_BEAT) begin
                     done    = 1'b1;
                     beat_d  = '0;
                     state_d = S_IDLE;
                  end else begin
                     beat_d = beat_q + CNT_W'(1);
                  end
               end
            end else if (tmo_q == '0) begin
               abort   = 1'b1;
               beat_d  = '0;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q - TMO_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The final beat only partly fits; its upper payload bits are dropped.
   always_comb begin
      asm_d = asm_q;
      if (wr_en) begin
         for (int k = 0; k < NUMBER_PACKET - 1; k++) begin
            if (beat_q == CNT_W'(k))
               asm_d[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = payload;
         end
         if (beat_q == LAST_BEAT)
            asm_d[DATA_DFX_WIDTH-1:LAST_LO] = payload[LAST_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_q     <= '0;
         dfx_q     <= '0;
         hdr_out_q <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         asm_q   <= asm_d;
         valid_q <= done;
         err_q   <= abort;
         if (done) begin
            dfx_q     <= asm_d;
            hdr_out_q <= hdr_q;
         end
      end
   end

   assign bus.data_dfx_recv   = dfx_q;
   assign bus.header_pkt_recv = hdr_out_q;
   assign bus.data_dfx_valid  = valid_q;
   assign bus.pkt_error       = err_q;

endmodule
